multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 44 ++++
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the datapath.
// Latency: none. Wires only, the interface holds no state.
// Backpressure: none. The controller's wait states are driven by MemReady.
// Ports:
//   datapath -> controller: OP, Funct, Zero, MemReady
//   controller -> datapath: PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
//                           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
//                           PCSource, State, IllegalOp
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if;
  // instruction fields and datapath status
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  // datapath controls
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;
  logic       IllegalOp;

  modport master (
    input  OP, Funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, IllegalOp
  );

  modport slave (
    output OP, Funct, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, IllegalOp
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM. It sequences fetch, decode, execute, memory and writeback.
// Latency: lw 5 cycles, sw/R-type/I-type 4, branch/j/jal/jr 3, plus memory wait cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold while MemReady is low. Other states ignore it.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : multicycle_control_if.master, which carries the opcode/status inputs and all control outputs
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12,
    JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  state_t state_q;
  state_t next_state;
  logic   illegal_q;
  logic   set_illegal;

  // Reset blocks the completion of a fetch. Without this gate, PCEn or
  // IRWrite could pulse while reset is held with MemReady high.
  logic   mem_ready;
  assign mem_ready = bus.MemReady & reset;

  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= next_state;
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state and Moore output decode. Every control defaults to 0, so each
  // state only lists the signals it asserts.
  always_comb begin
    next_state  = FETCH;
    set_illegal = 1'b0;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_ADD;
    pc_source   = 2'd0;

    case (state_q)
      FETCH: begin
        // The ALU computes PC+4 while the instruction is read.
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end

      DECODE: begin
        // The branch target goes into ALUOut before the opcode is known.
        alu_src_b = 2'd3;
        case (bus.OP)
          OP_LW, OP_SW:            next_state = MEMADR;
          OP_RTYPE:                next_state = (bus.Funct == FN_JR) ? JR : RTEXEC;
          OP_BEQ, OP_BNE:          next_state = BRANCH;
          OP_ADDI, OP_ORI, OP_LUI: next_state = IEXEC;
          OP_J:                    next_state = JUMP;
          OP_JAL:                  next_state = JAL;
          default: begin
            set_illegal = 1'b1;
            next_state  = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        next_state = (bus.OP == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        i_or_d     = 1'b1;
        mem_read   = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end

      MEMWB: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready ? FETCH : MEMWR;
      end

      RTEXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNC;
        next_state = ALUWB;
      end

      ALUWB: begin
        reg_dst    = 2'd1;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        // The ALU compares rs and rt. The PC takes the target held in ALUOut
        // since DECODE.
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 2'd1;
        pc_en      = (bus.OP == OP_BEQ) ? bus.Zero : ~bus.Zero;
        next_state = FETCH;
      end

      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (bus.OP)
          OP_ORI:  alu_op = ALU_OR;
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
        next_state = IWB;
      end

      IWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      JUMP: begin
        pc_source  = 2'd2;
        pc_en      = 1'b1;
        next_state = FETCH;
      end

      JAL: begin
        // The link write uses the PC value, which is already PC+4, in the
        // same cycle that the PC takes the jump target.
        pc_source  = 2'd2;
        pc_en      = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      JR: begin
        pc_source  = 2'd3;
        pc_en      = 1'b1;
        next_state = FETCH;
      end

      default: begin
        // Codes 14 and 15 recover to FETCH with every output inactive.
        next_state = FETCH;
      end
    endcase
  end

  assign bus.PCEn      = pc_en;
  assign bus.IorD      = i_or_d;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegDst    = reg_dst;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.RegWrite  = reg_write;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.PCSource  = pc_source;
  assign bus.State     = state_q;
  assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Instructions are planned from their class,
// the expected per-cycle controls are queued, and a monitor checks them.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
    logic [3:0] state;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  logic clk;
  logic reset;
  multicycle_control_if bus_if ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   model_ill = 1'b0;
  ctl_t mon_act;
  ctl_t mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.pcen     = bus_if.PCEn;
    c.iord     = bus_if.IorD;
    c.memread  = bus_if.MemRead;
    c.memwrite = bus_if.MemWrite;
    c.irwrite  = bus_if.IRWrite;
    c.regdst   = bus_if.RegDst;
    c.memtoreg = bus_if.MemtoReg;
    c.regwrite = bus_if.RegWrite;
    c.alusrca  = bus_if.ALUSrcA;
    c.alusrcb  = bus_if.ALUSrcB;
    c.aluop    = bus_if.ALUOp;
    c.pcsource = bus_if.PCSource;
    c.state    = bus_if.State;
    c.illegal  = bus_if.IllegalOp;
    return c;
  endfunction

  // Controls required in each step of an instruction, written out step by step.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                   input logic zero, input logic mr, input logic ill);
    ctl_t c;
    c = '0;
    c.state   = st;
    c.illegal = ill;
    case (st)
      4'd0:  begin c.memread = 1'b1; c.alusrcb = 2'd1; c.pcen = mr; c.irwrite = mr; end
      4'd1:  c.alusrcb = 2'd3;
      4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; end
      4'd3:  begin c.iord = 1'b1; c.memread = 1'b1; end
      4'd4:  begin c.memtoreg = 2'd1; c.regwrite = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      4'd6:  begin c.alusrca = 1'b1; c.aluop = 3'b010; end
      4'd7:  begin c.regdst = 2'd1; c.regwrite = 1'b1; end
      4'd8:  begin
        c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsource = 2'd1;
        c.pcen = (op == 6'h04) ? zero : ~zero;
      end
      4'd9:  begin
        c.alusrca = 1'b1; c.alusrcb = 2'd2;
        c.aluop = (op == 6'h0D) ? 3'b011 : (op == 6'h0F) ? 3'b100 : 3'b000;
      end
      4'd10: c.regwrite = 1'b1;
      4'd11: begin c.pcsource = 2'd2; c.pcen = 1'b1; end
      4'd12: begin
        c.pcsource = 2'd2; c.pcen = 1'b1; c.regdst = 2'd2;
        c.memtoreg = 2'd2; c.regwrite = 1'b1;
      end
      4'd13: begin c.pcsource = 2'd3; c.pcen = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic step_t mk(input int st, input logic mr);
    step_t s;
    s.st = 4'(st);
    s.mr = mr;
    return s;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: compare every cycle the driver has queued an expectation for.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = sample();
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_underflow actual=%h required=<queued entry>", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk($sformatf("ctl_state%0d", mon_exp.state), 32'(mon_act), 32'(mon_exp));
      end
      chk("memread_memwrite_excl", 32'(mon_act.memread & mon_act.memwrite), 32'd0);
      chk("regwrite_memwrite_excl", 32'(mon_act.regwrite & mon_act.memwrite), 32'd0);
    end
  end

  // Called at posedge+1 of a cycle in the planned step st_now. Reset drops
  // mid-cycle, and the outputs must return to FETCH at once.
  task automatic do_abort(input logic [3:0] st_now);
    chk("pre_abort_state", 32'(bus_if.State), 32'(st_now));
    mon_en = 1'b0;
    bus_if.MemReady = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(bus_if.State), 32'd0);
    chk("abort_memwrite", 32'(bus_if.MemWrite), 32'd0);
    chk("abort_regwrite", 32'(bus_if.RegWrite), 32'd0);
    chk("abort_memread", 32'(bus_if.MemRead), 32'd1);
    chk("abort_illegal", 32'(bus_if.IllegalOp), 32'd0);
    bus_if.MemReady = 1'b1;
    #1;
    chk("abort_pcen_forced", 32'(bus_if.PCEn), 32'd0);
    chk("abort_irwrite_forced", 32'(bus_if.IRWrite), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_state", 32'(bus_if.State), 32'd0);
    reset = 1'b1;
    model_ill = 1'b0;
    mon_en = 1'b1;
  endtask

  // Plan one instruction from its class and queue each step's expected controls.
  // The task starts and returns at posedge+1.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input int fwait, input int mwait, input int abort_at);
    step_t plan[$];
    bit    is_ill;
    plan   = {};
    is_ill = 1'b0;
    for (int i = 0; i < fwait; i++) plan.push_back(mk(0, 1'b0));
    plan.push_back(mk(0, 1'b1));
    plan.push_back(mk(1, rnd_bit()));
    if (op == 6'h23 || op == 6'h2B) begin
      plan.push_back(mk(2, rnd_bit()));
      for (int i = 0; i < mwait; i++) plan.push_back(mk((op == 6'h23) ? 3 : 5, 1'b0));
      plan.push_back(mk((op == 6'h23) ? 3 : 5, 1'b1));
      if (op == 6'h23) plan.push_back(mk(4, rnd_bit()));
    end else if (op == 6'h00) begin
      if (funct == 6'h08) plan.push_back(mk(13, rnd_bit()));
      else begin plan.push_back(mk(6, rnd_bit())); plan.push_back(mk(7, rnd_bit())); end
    end else if (op == 6'h04 || op == 6'h05) begin
      plan.push_back(mk(8, rnd_bit()));
    end else if (op == 6'h08 || op == 6'h0D || op == 6'h0F) begin
      plan.push_back(mk(9, rnd_bit()));
      plan.push_back(mk(10, rnd_bit()));
    end else if (op == 6'h02) begin
      plan.push_back(mk(11, rnd_bit()));
    end else if (op == 6'h03) begin
      plan.push_back(mk(12, rnd_bit()));
    end else begin
      is_ill = 1'b1;
    end

    bus_if.OP    = op;
    bus_if.Funct = funct;
    bus_if.Zero  = zero;
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abort_at) begin
        do_abort(plan[i].st);
        return;
      end
      bus_if.MemReady = plan[i].mr;
      exp_q.push_back(exp_ctl(plan[i].st, op, zero, plan[i].mr, model_ill));
      if (plan[i].st == 4'd1 && is_ill) model_ill = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_pool [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                               6'h0D, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h11};

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    int         rab;

    reset           = 1'b0;
    bus_if.MemReady = 1'b0;
    bus_if.OP       = 6'h00;
    bus_if.Funct    = 6'h00;
    bus_if.Zero     = 1'b0;
    #2;
    chk("reset_state", 32'(bus_if.State), 32'd0);
    chk("reset_memread", 32'(bus_if.MemRead), 32'd1);
    chk("reset_illegal", 32'(bus_if.IllegalOp), 32'd0);
    bus_if.MemReady = 1'b1;
    #1;
    chk("reset_pcen", 32'(bus_if.PCEn), 32'd0);
    chk("reset_irwrite", 32'(bus_if.IRWrite), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_state", 32'(bus_if.State), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);   // add: states 0,1,6,7
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1);   // lw with 3 wait cycles in MEMRD
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, -1);   // bne not taken
    run_instr(6'h05, 6'h00, 1'b0, 1, 0, -1);   // bne taken
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);   // beq not taken
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, -1);   // jal
    run_instr(6'h02, 6'h00, 1'b0, 2, 0, -1);   // j
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, -1);   // jr
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);   // addi
    run_instr(6'h0D, 6'h00, 1'b0, 0, 0, -1);   // ori
    run_instr(6'h0F, 6'h00, 1'b0, 0, 0, -1);   // lui
    run_instr(6'h2B, 6'h00, 1'b0, 0, 2, -1);   // sw with waits
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);   // illegal: 0,1,0 then sticky flag
    run_instr(6'h00, 6'h22, 1'b0, 0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 1, 1, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 4, 5);    // reset during the MEMWR wait
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, -1);   // no write carried over from the aborted store
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 4);    // reset during the MEMRD wait

    // Randomised instruction stream, with occasional aborts.
    for (int n = 0; n < 80; n++) begin
      rop = op_pool[$urandom_range(0, 11)];
      rfn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      rab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_instr(rop, rfn, rnd_bit(), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), rab);
    end

    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
